// File: rtl/uart_fifo_ctrl_if.sv
// Host-side and rs232c-side signal bundle for uart_fifo_ctrl.
// slave = the FIFO controller; master = host plus serial core.
interface uart_fifo_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [7:0]          WR_DATA;
    logic                WR_EN;
    logic                TX_FULL;
    logic                TX_IDLE;
    logic [7:0]          RD_DATA;
    logic                RD_EN;
    logic                RX_EMPTY;
    logic [DEPTH_LOG2:0] RX_COUNT;
    logic                RX_OVERRUN;
    logic                OVR_CLR;
    logic [7:0]          U_TX_DATA;
    logic                U_TX_DATA_EN;
    logic                U_TX_BUSY;
    logic [7:0]          U_RX_DATA;
    logic                U_RX_DATA_RDY;
    logic                U_RX_DATA_RD;

    modport master (
        output WR_DATA, WR_EN, RD_EN, OVR_CLR, U_TX_BUSY, U_RX_DATA, U_RX_DATA_RDY,
        input  TX_FULL, TX_IDLE, RD_DATA, RX_EMPTY, RX_COUNT, RX_OVERRUN,
               U_TX_DATA, U_TX_DATA_EN, U_RX_DATA_RD
    );

    modport slave (
        input  WR_DATA, WR_EN, RD_EN, OVR_CLR, U_TX_BUSY, U_RX_DATA, U_RX_DATA_RDY,
        output TX_FULL, TX_IDLE, RD_DATA, RX_EMPTY, RX_COUNT, RX_OVERRUN,
               U_TX_DATA, U_TX_DATA_EN, U_RX_DATA_RD
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// TX/RX byte FIFOs with launcher and drain FSMs between host and rs232c core.
// Define UART_FIFO_LOOPBACK_EN to add the LOOPBACK port (TX FIFO feeds RX FIFO directly).
module uart_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic CLK,
    input  logic RESETB,
`ifdef UART_FIFO_LOOPBACK_EN
    input  logic LOOPBACK,
`endif
    uart_fifo_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] T_ARM  = 2'd1;
    localparam logic [1:0] T_WAIT = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_ACK  = 1'b1;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [1:0]    tx_state;
    logic [0:0]    rx_state;

    logic          tx_full_q, rx_empty_q, ovr_q, tx_en_q, rx_rd_q;
    logic [7:0]    tx_data_q, rd_data_q;
    logic [PW-1:0] rx_count_q;

    logic          lb;
    logic          tx_empty_i, tx_full_i, rx_empty_i, rx_full_i;
    logic          tx_push, tx_pop, rx_pop, rx_room, uart_rx, rx_push, ovr_set;
    logic [7:0]    tx_head, rx_din;

`ifdef UART_FIFO_LOOPBACK_EN
    assign lb = LOOPBACK;
`else
    assign lb = 1'b0;
`endif

    assign tx_empty_i = (tx_wptr == tx_rptr);
    assign tx_full_i  = (tx_wptr[PW-1] != tx_rptr[PW-1]) && (tx_wptr[PW-2:0] == tx_rptr[PW-2:0]);
    assign rx_empty_i = (rx_wptr == rx_rptr);
    assign rx_full_i  = (rx_wptr[PW-1] != rx_rptr[PW-1]) && (rx_wptr[PW-2:0] == rx_rptr[PW-2:0]);
    assign tx_head    = tx_mem[tx_rptr[PW-2:0]];

    // Push/pop gating uses live pointers; the exported flags lag by one register stage.
    assign tx_push = bus.WR_EN && !tx_full_i;
    assign rx_pop  = bus.RD_EN && !rx_empty_i;
    assign rx_room = !rx_full_i || rx_pop;
    assign tx_pop  = (tx_state == IDLE) && !tx_empty_i && (!lb || rx_room);
    assign uart_rx = !lb && (rx_state == R_IDLE) && bus.U_RX_DATA_RDY;
    assign rx_push = lb ? tx_pop : (uart_rx && rx_room);
    assign rx_din  = lb ? tx_head : bus.U_RX_DATA;
    assign ovr_set = uart_rx && !rx_room;

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wptr[PW-2:0]] <= bus.WR_DATA;
        if (rx_push) rx_mem[rx_wptr[PW-2:0]] <= rx_din;
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            tx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            rx_count_q <= '0;
            rd_data_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
            if (rx_push) rx_wptr <= rx_wptr + PW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
            tx_full_q  <= tx_full_i;
            rx_empty_q <= rx_empty_i;
            rx_count_q <= rx_wptr - rx_rptr;
            rd_data_q  <= rx_empty_i ? '0 : rx_mem[rx_rptr[PW-2:0]];
            if (ovr_set)          ovr_q <= 1'b1;
            else if (bus.OVR_CLR) ovr_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            tx_state  <= IDLE;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (tx_state)
                IDLE: if (tx_pop) begin
                    tx_state <= T_ARM;
                    if (!lb) begin
                        tx_data_q <= tx_head;
                        tx_en_q   <= 1'b1;
                    end
                end
                T_ARM: begin
                    if (lb)                tx_state <= IDLE;
                    else if (bus.U_TX_BUSY) tx_state <= T_WAIT;
                end
                T_WAIT:  if (!bus.U_TX_BUSY) tx_state <= IDLE;
                default: tx_state <= IDLE;
            endcase
        end
    end

    // R_ACK skips one cycle so the core's registered RDY clear is never re-sampled.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            rx_state <= R_IDLE;
            rx_rd_q  <= 1'b0;
        end else begin
            rx_rd_q <= 1'b0;
            case (rx_state)
                R_IDLE: if (uart_rx) begin
                    rx_rd_q  <= 1'b1;
                    rx_state <= R_ACK;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    assign bus.TX_FULL      = tx_full_q;
    assign bus.TX_IDLE      = tx_empty_i && (tx_state == IDLE);
    assign bus.RD_DATA      = rd_data_q;
    assign bus.RX_EMPTY     = rx_empty_q;
    assign bus.RX_COUNT     = rx_count_q;
    assign bus.RX_OVERRUN   = ovr_q;
    assign bus.U_TX_DATA    = tx_data_q;
    assign bus.U_TX_DATA_EN = tx_en_q;
    assign bus.U_RX_DATA_RD = rx_rd_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Randomized bench for uart_fifo_ctrl against a queue-based model and a simple rs232c stand-in.
module tb_uart_fifo_ctrl;
    localparam int DEPTH = 16;
    localparam int FRAME = 10;

    logic CLK = 1'b0;
    logic RESETB;
    bit   hold_busy;
    int   busy_cnt = 0;

    uart_fifo_ctrl_if #(.DEPTH_LOG2(4)) bus ();

    uart_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
        .CLK      (CLK),
        .RESETB   (RESETB),
`ifdef UART_FIFO_LOOPBACK_EN
        .LOOPBACK (1'b0),
`endif
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    // rs232c stand-in: a frame keeps TX_BUSY high for FRAME cycles, independent of our reset.
    assign bus.U_TX_BUSY = hold_busy || (busy_cnt != 0);
    always @(negedge CLK) begin
        if (bus.U_TX_DATA_EN)  busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit ovr_exp, rx_new, have_last_en;
    int cyc, last_en, en_count, rd_count, tx_pushes;
    int n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock: update the model with this cycle's inputs, then observe DUT pulses.
    task automatic step();
        bit pre_en, pre_rd, popping, accept, set;
        pre_en  = bus.U_TX_DATA_EN;
        pre_rd  = bus.U_RX_DATA_RD;
        set     = 1'b0;
        accept  = RESETB && bus.WR_EN && (tx_q.size() < DEPTH);
        popping = RESETB && bus.RD_EN && (rx_q.size() > 0);
        if (accept) begin
            tx_q.push_back(bus.WR_DATA);
            tx_pushes++;
        end
        if (popping) void'(rx_q.pop_front());
        if (rx_new && RESETB) begin
            rx_new = 1'b0;
            if (rx_q.size() < DEPTH) rx_q.push_back(bus.U_RX_DATA);
            else set = 1'b1;
        end
        if (set) ovr_exp = 1'b1;
        else if (RESETB && bus.OVR_CLR) ovr_exp = 1'b0;
        @(posedge CLK);
        #1;
        cyc++;
        if (bus.U_TX_DATA_EN) begin
            check("tx_en_width", 32'(pre_en), 0);
            if (have_last_en) check("tx_en_gap", 32'((cyc - last_en) >= FRAME + 2), 1);
            if (tx_q.size() == 0) check("tx_en_spurious", 1, 0);
            else check("tx_data", bus.U_TX_DATA, tx_q.pop_front());
            last_en = cyc;
            have_last_en = 1'b1;
            en_count++;
        end
        if (bus.U_RX_DATA_RD) begin
            check("rx_rd_width", 32'(pre_rd), 0);
            rd_count++;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_tx_full",  bus.TX_FULL, 0);
        check("rst_tx_idle",  bus.TX_IDLE, 1);
        check("rst_rd_data",  bus.RD_DATA, 0);
        check("rst_rx_empty", bus.RX_EMPTY, 1);
        check("rst_rx_count", bus.RX_COUNT, 0);
        check("rst_overrun",  bus.RX_OVERRUN, 0);
        check("rst_tx_data",  bus.U_TX_DATA, 0);
        check("rst_tx_en",    bus.U_TX_DATA_EN, 0);
        check("rst_rx_rd",    bus.U_RX_DATA_RD, 0);
    endtask

    task automatic do_reset();
        RESETB = 1'b0;
        #1;
        check_reset_vals();
        tx_q.delete();
        rx_q.delete();
        ovr_exp = 1'b0;
        rx_new = 1'b0;
        have_last_en = 1'b0;
        step();
        step();
        RESETB = 1'b1;
        step();
    endtask

    task automatic rx_status();
        check("rx_count",   bus.RX_COUNT, rx_q.size());
        check("rx_empty",   bus.RX_EMPTY, 32'(rx_q.size() == 0));
        check("rd_data",    bus.RD_DATA, (rx_q.size() == 0) ? 8'h00 : rx_q[0]);
        check("rx_overrun", bus.RX_OVERRUN, 32'(ovr_exp));
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit with_pop);
        int rd0;
        rd0 = rd_count;
        bus.U_RX_DATA = b;
        bus.U_RX_DATA_RDY = 1'b1;
        bus.RD_EN = with_pop;
        rx_new = 1'b1;
        step();
        bus.RD_EN = 1'b0;
        check("rx_rd_pulse", bus.U_RX_DATA_RD, 1);
        step();
        bus.U_RX_DATA_RDY = 1'b0;
        step();
        step();
        check("rx_rd_once", rd_count - rd0, 1);
    endtask

    task automatic rx_drain();
        int n;
        n = 0;
        while (rx_q.size() > 0 && n < 40) begin
            check("rx_order", bus.RD_DATA, rx_q[0]);
            bus.RD_EN = 1'b1;
            step();
            bus.RD_EN = 1'b0;
            step();
            n++;
        end
        step();
        rx_status();
    endtask

    task automatic tx_drain(input int budget);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("tx_drain_done", tx_q.size(), 0);
        repeat (FRAME + 6) step();
        check("tx_idle", bus.TX_IDLE, 1);
        check("tx_full_clear", bus.TX_FULL, 0);
    endtask

    task automatic wait_launch(input int en0);
        int n;
        n = 0;
        while (en_count == en0 && n < 20) begin
            step();
            n++;
        end
        check("tx_launch_seen", en_count - en0, 1);
    endtask

    initial begin
        int en0, rd0, p0;
        logic [7:0] b;
        RESETB = 1'b1;
        hold_busy = 1'b0;
        bus.WR_DATA = '0;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        bus.OVR_CLR = 1'b0;
        bus.U_RX_DATA = '0;
        bus.U_RX_DATA_RDY = 1'b0;
        #2;
        do_reset();

        // Two bytes, second paced by TX_BUSY
        en0 = en_count;
        bus.WR_EN = 1'b1;
        bus.WR_DATA = 8'h55;
        step();
        bus.WR_DATA = 8'hA3;
        step();
        bus.WR_EN = 1'b0;
        tx_drain(200);
        check("t1_launches", en_count - en0, 2);

        // 17 writes against a stalled launcher
        en0 = en_count;
        bus.WR_EN = 1'b1;
        bus.WR_DATA = 8'hEE;
        step();
        bus.WR_EN = 1'b0;
        wait_launch(en0);
        hold_busy = 1'b1;
        bus.WR_EN = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.WR_DATA = 8'($urandom);
            step();
        end
        bus.WR_EN = 1'b0;
        step();
        check("t2_tx_full", bus.TX_FULL, 1);
        check("t2_tx_busy_idle", bus.TX_IDLE, 0);
        hold_busy = 1'b0;
        tx_drain(16 * (FRAME + 4) + 100);
        check("t2_launches", en_count - en0, 17);

        // Random sparse writes, possibly overfilling
        en0 = en_count;
        p0 = tx_pushes;
        for (int i = 0; i < 30; i++) begin
            bus.WR_EN = 1'($urandom_range(0, 1));
            bus.WR_DATA = 8'($urandom);
            step();
        end
        bus.WR_EN = 1'b0;
        tx_drain(20 * (FRAME + 4) + 100);
        check("t2b_launches", en_count - en0, tx_pushes - p0);

        // Single RX byte latency
        rd0 = rd_count;
        bus.U_RX_DATA = 8'h3C;
        bus.U_RX_DATA_RDY = 1'b1;
        rx_new = 1'b1;
        step();
        check("t3_rd_pulse", bus.U_RX_DATA_RD, 1);
        step();
        bus.U_RX_DATA_RDY = 1'b0;
        check("t3_rd_data", bus.RD_DATA, 8'h3C);
        check("t3_rx_count", bus.RX_COUNT, 1);
        check("t3_rd_low", bus.U_RX_DATA_RD, 0);
        step();
        step();
        check("t3_rd_once", rd_count - rd0, 1);
        rx_status();

        // Fill to 16, then overrun
        for (int i = 0; i < 15; i++) rx_byte(8'($urandom), 1'b0);
        rx_status();
        rx_byte(8'h99, 1'b0);
        rx_status();
        check("t4_overrun", bus.RX_OVERRUN, 1);
        check("t4_head", bus.RD_DATA, 8'h3C);
        bus.OVR_CLR = 1'b1;
        step();
        bus.OVR_CLR = 1'b0;
        step();
        check("t4_ovr_clr", bus.RX_OVERRUN, 0);

        // Full FIFO, pop and push together
        b = 8'($urandom);
        rx_byte(b, 1'b1);
        rx_status();
        check("t5_count", bus.RX_COUNT, 16);
        check("t5_no_overrun", bus.RX_OVERRUN, 0);
        check("t5_last", rx_q[DEPTH-1], b);
        rx_drain();

        // Random RX traffic with random pops
        for (int i = 0; i < 24; i++) begin
            rx_byte(8'($urandom), 1'($urandom_range(0, 1)));
            rx_status();
        end
        bus.OVR_CLR = 1'b1;
        step();
        bus.OVR_CLR = 1'b0;
        rx_drain();

        // Reset while in T_WAIT with 3 bytes queued
        rx_byte(8'($urandom), 1'b0);
        en0 = en_count;
        bus.WR_EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.WR_DATA = 8'($urandom);
            step();
        end
        bus.WR_EN = 1'b0;
        wait_launch(en0);
        repeat (3) step();
        check("t6_busy_before_rst", bus.TX_IDLE, 0);
        do_reset();
        en0 = en_count;
        repeat (FRAME + 20) step();
        check("t6_no_en", en_count - en0, 0);
        check("t6_tx_idle", bus.TX_IDLE, 1);
        check("t6_rx_empty", bus.RX_EMPTY, 1);
        bus.WR_EN = 1'b1;
        bus.WR_DATA = 8'($urandom);
        step();
        bus.WR_EN = 1'b0;
        tx_drain(100);
        check("t6_new_launch", en_count - en0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
